// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    typedef enum logic {
        PARK = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Zero means open-ended (INCR).
    function automatic logic [4:0] beats_of(hburst_t burst);
        logic [4:0] beats;
        case (burst)
            SINGLE:         beats = 5'd1;
            INCR:           beats = 5'd0;
            WRAP4, INCR4:   beats = 5'd4;
            WRAP8, INCR8:   beats = 5'd8;
            WRAP16, INCR16: beats = 5'd16;
            default:        beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping modulo NUM_MASTERS.
module ahb_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          ptr_i,
    output logic [NUM_MASTERS-1:0] onehot_o,
    output logic [MW-1:0]          idx_o,
    output logic                   any_o
);

    logic [MW-1:0] cand;

    // ptr_i itself is searched last, so the previous winner has lowest priority.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((32'(ptr_i) + k) % NUM_MASTERS);
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                idx_o           = cand;
                onehot_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter that holds the grant for fixed-length bursts and
// tracks address-phase (HMASTER) and data-phase (HMASTER_D) owners.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    localparam int unsigned MW            = $clog2(NUM_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NUM_MASTERS-1:0]   HBUSREQ,
    input  logic [2*NUM_MASTERS-1:0] HTRANS_M,
    input  logic [3*NUM_MASTERS-1:0] HBURST_M,
    input  logic                     HREADY,
    output logic [NUM_MASTERS-1:0]   HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic [MW-1:0]            HMASTER_D
);

    localparam logic [MW-1:0]          DefIdx   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DefGrant = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          grant_idx_q, grant_idx_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [MW-1:0]          downer_q, downer_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [4:0]             beats_q, beats_d;

    logic [1:0]             trans_m [NUM_MASTERS];
    logic [2:0]             burst_m [NUM_MASTERS];
    htrans_t                trans;
    hburst_t                burst;
    logic [4:0]             burst_len;
    logic                   owner_req;
    logic                   incr_hold;
    logic                   regrant;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [MW-1:0]          pick_idx;
    logic                   pick_any;

    ahb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .MW         (MW)
    ) u_pick (
        .req_i   (HBUSREQ),
        .ptr_i   (rr_ptr_q),
        .onehot_o(pick_onehot),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            trans_m[i] = HTRANS_M[2*i +: 2];
            burst_m[i] = HBURST_M[3*i +: 3];
        end
    end

    assign trans     = htrans_t'(trans_m[hmaster_q]);
    assign burst     = hburst_t'(burst_m[hmaster_q]);
    assign burst_len = beats_of(burst);
    assign owner_req = HBUSREQ[hmaster_q];

    // Open-ended INCR keeps the bus in PARK; the owner keeps it while it asks and is not idle.
    assign incr_hold = (burst == INCR) && (trans != IDLE) && owner_req
                       && (grant_idx_q == hmaster_q);

    always_comb begin
        beats_d = beats_q;
        if (HREADY) begin
            case (trans)
                NONSEQ:  beats_d = (burst_len == 5'd0) ? 5'd0 : burst_len - 5'd1;
                SEQ:     beats_d = (beats_q == 5'd0) ? 5'd0 : beats_q - 5'd1;
                BUSY:    beats_d = beats_q;
                IDLE:    beats_d = 5'd0;
                default: beats_d = beats_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        regrant     = 1'b0;
        hmaster_d   = hmaster_q;
        downer_d    = downer_q;

        if (HREADY) begin
            hmaster_d = grant_idx_q;
            downer_d  = hmaster_q;
            case (state_q)
                PARK: begin
                    if (trans == NONSEQ && burst_len > 5'd1) begin
                        state_d = LOCK;
                    end else if (!incr_hold) begin
                        regrant = 1'b1;
                    end
                end
                LOCK: begin
                    // Leaving at beats_left==1 re-grants during the last address phase.
                    if (((trans == NONSEQ || trans == SEQ) && beats_d == 5'd1)
                        || trans == IDLE || !owner_req) begin
                        state_d = PARK;
                        regrant = 1'b1;
                    end
                end
                default: state_d = PARK;
            endcase
        end

        if (regrant) begin
            if (pick_any) begin
                grant_d     = pick_onehot;
                grant_idx_d = pick_idx;
                if (pick_idx != grant_idx_q) begin
                    rr_ptr_d = pick_idx;
                end
            end else begin
                grant_d     = DefGrant;
                grant_idx_d = DefIdx;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= PARK;
            grant_q     <= DefGrant;
            grant_idx_q <= DefIdx;
            hmaster_q   <= DefIdx;
            downer_q    <= DefIdx;
            rr_ptr_q    <= DefIdx;
            beats_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            hmaster_q   <= hmaster_d;
            downer_q    <= downer_d;
            rr_ptr_q    <= rr_ptr_d;
            beats_q     <= beats_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = downer_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus randomized traffic, checked against an integer-level arbiter model.
module tb_ahb_bus_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3;
    localparam logic [2:0] B_INCR8 = 3'd5, B_INCR16 = 3'd7;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [3:0]  HBUSREQ;
    logic [7:0]  HTRANS_M;
    logic [11:0] HBURST_M;
    logic        HREADY;
    logic [3:0]  HGRANT;
    logic [1:0]  HMASTER;
    logic [1:0]  HMASTER_D;

    int n_vec;
    int n_err;

    // Model state: plain integers for grant/owners/counter, a flag for burst lock.
    int m_grant, m_own, m_down, m_beats, m_rr;
    bit m_lock;

    ahb_bus_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HBUSREQ  (HBUSREQ),
        .HTRANS_M (HTRANS_M),
        .HBURST_M (HBURST_M),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTER_D(HMASTER_D)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int burst_len(input int b);
        case (b)
            0:       return 1;
            1:       return 0;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int pick(input int rr, input logic [3:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(rr + k) % N]) return (rr + k) % N;
        end
        return DEF;
    endfunction

    task automatic model_step();
        int  t, b, bl, nb, np;
        bit  oreq, regrant;
        if (HRESET) begin
            m_grant = DEF; m_own = DEF; m_down = DEF;
            m_beats = 0;   m_rr = DEF;  m_lock = 1'b0;
            return;
        end
        if (!HREADY) return;
        t    = int'((HTRANS_M >> (2 * m_own)) & 8'd3);
        b    = int'((HBURST_M >> (3 * m_own)) & 12'd7);
        bl   = burst_len(b);
        oreq = HBUSREQ[m_own];
        nb   = m_beats;
        if (t == 2)      nb = (bl == 0) ? 0 : bl - 1;
        else if (t == 3) nb = (m_beats > 0) ? m_beats - 1 : 0;
        else if (t == 0) nb = 0;
        regrant = 1'b0;
        if (!m_lock) begin
            if (t == 2 && bl > 1) m_lock = 1'b1;
            else if (!(b == 1 && t != 0 && oreq && m_grant == m_own)) regrant = 1'b1;
        end else if (((t == 2 || t == 3) && nb == 1) || t == 0 || !oreq) begin
            m_lock  = 1'b0;
            regrant = 1'b1;
        end
        np = regrant ? pick(m_rr, HBUSREQ) : m_grant;
        if (np != m_grant && HBUSREQ[np]) m_rr = np;
        m_down  = m_own;
        m_own   = m_grant;
        m_grant = np;
        m_beats = nb;
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
        check("model_grant", HGRANT, 32'(1) << m_grant);
        check("model_hmaster", HMASTER, m_own);
        check("model_hmaster_d", HMASTER_D, m_down);
    endtask

    task automatic set_m(input int m, input logic [1:0] t, input logic [2:0] b);
        HTRANS_M[2*m +: 2] = t;
        HBURST_M[3*m +: 3] = b;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        tick();
        HRESET   = 1'b0;
        HBUSREQ  = '0;
        HTRANS_M = '0;
        HBURST_M = '0;
        HREADY   = 1'b1;
    endtask

    int tr4[11] = '{2, 3, 1, 3, 3, 3, 3, 3, 3, 3, 3};
    int rd4[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    int gr4[11] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 8};
    int ord3[5] = '{1, 2, 3, 0, 1};

    initial begin
        n_vec = 0; n_err = 0;
        HRESET = 1'b1; HBUSREQ = '0; HTRANS_M = '0; HBURST_M = '0; HREADY = 1'b1;

        // Reset and first edge after reset with no requests
        tick();
        check("rst_grant", HGRANT, 4'b0001);
        check("rst_hmaster", HMASTER, 0);
        HRESET = 1'b0;
        tick();
        check("t1_grant", HGRANT, 4'b0001);
        check("t1_hmaster", HMASTER, 0);
        check("t1_hmaster_d", HMASTER_D, 0);

        // M1 INCR4 while M2 requests throughout
        HBUSREQ = 4'b0010;
        tick();
        check("t2_req_grant", HGRANT, 4'b0010);
        tick();
        check("t2_owner", HMASTER, 1);
        HBUSREQ = 4'b0110;
        set_m(1, T_NSEQ, B_INCR4);
        tick();
        check("t2_beat1", HGRANT, 4'b0010);
        set_m(1, T_SEQ, B_INCR4);
        tick();
        check("t2_beat2", HGRANT, 4'b0010);
        tick();
        check("t2_last_phase_regrant", HGRANT, 4'b0100);
        HBUSREQ = 4'b0100;
        tick();
        check("t2_m2_owner", HMASTER, 2);
        check("t2_m1_data", HMASTER_D, 1);
        set_m(1, T_IDLE, B_SINGLE);
        set_m(2, T_NSEQ, B_SINGLE);
        tick();
        check("t2_m2_data", HMASTER_D, 2);

        // All four request SINGLE transfers from rr_ptr=0
        do_reset();
        HBUSREQ  = 4'b1111;
        HTRANS_M = 8'b10101010;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_rr_order", HGRANT, 32'(1) << ord3[i]);
        end

        // M1 INCR8 with BUSY and an HREADY stall; M3 waiting
        do_reset();
        HBUSREQ = 4'b0010;
        tick();
        tick();
        HBUSREQ = 4'b1010;
        for (int i = 0; i < 11; i++) begin
            set_m(1, 2'(tr4[i]), B_INCR8);
            HREADY = rd4[i][0];
            tick();
            check("t4_grant", HGRANT, gr4[i]);
            if (rd4[i] == 0) check("t4_stall_owner", HMASTER, 1);
        end
        HREADY = 1'b1;

        // M2 INCR16 terminated early by IDLE while M3 requests, then reset mid-burst
        do_reset();
        HBUSREQ = 4'b0100;
        tick();
        tick();
        HBUSREQ = 4'b1100;
        set_m(2, T_NSEQ, B_INCR16);
        tick();
        check("t5_lock", HGRANT, 4'b0100);
        set_m(2, T_SEQ, B_INCR16);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold", HGRANT, 4'b0100);
        end
        set_m(2, T_IDLE, B_INCR16);
        tick();
        check("t5_idle_release", HGRANT, 4'b1000);
        HBUSREQ = 4'b1000;
        tick();
        set_m(3, T_NSEQ, B_INCR8);
        tick();
        check("t5_m3_lock", HGRANT, 4'b1000);
        set_m(3, T_SEQ, B_INCR8);
        tick();
        HRESET = 1'b1;
        tick();
        check("t5_rst_grant", HGRANT, 4'b0001);
        check("t5_rst_hmaster", HMASTER, 0);
        check("t5_rst_hmaster_d", HMASTER_D, 0);

        // M0 open-ended INCR, then drops its request while M1 waits
        do_reset();
        HBUSREQ = 4'b0011;
        set_m(0, T_NSEQ, B_INCR);
        tick();
        check("t6_incr_start", HGRANT, 4'b0001);
        set_m(0, T_SEQ, B_INCR);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t6_incr_hold", HGRANT, 4'b0001);
        end
        HBUSREQ = 4'b0010;
        tick();
        check("t6_release", HGRANT, 4'b0010);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) HBUSREQ = 4'($urandom);
            HTRANS_M = 8'($urandom);
            HBURST_M = 12'($urandom);
            HREADY   = ($urandom_range(0, 3) != 0);
            HRESET   = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
